ysyx_22050133_ifu: RTL and testbench

- Instruction fetch stage directly upstream of the decode stage.
- Holds the architectural PC and issues 32-bit fetch requests on a valid/ready instruction bus.
- Presents one instruction plus its PC to decode over a valid/ready handshake.
- Accepts PC redirects from execute (jumps, taken branches, traps) and squashes any fetch already in flight.

---
 rtl/ysyx_22050133_ifu.sv | 150 +++++++++++++++
 tb/tb_ysyx_22050133_ifu.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050133_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time on the
// instruction bus and hands the fetched word (plus its PC and a fault flag)
// to decode. Execute-stage redirects override everything; any fetch already
// on the bus when a redirect lands is marked for discard.
module ysyx_22050133_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifetch_req_valid,
  input  logic        ifetch_req_ready,
  output logic [63:0] ifetch_addr,
  input  logic        ifetch_rsp_valid,
  input  logic [31:0] ifetch_rsp_data,
  input  logic        ifetch_rsp_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] pc,
  output logic        inst_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [63:0] pc_reg;
  logic [31:0] inst_reg;
  logic        inst_err_reg;
  // Set when the in-flight response belongs to a PC that has been redirected away
  logic        kill_reg;

  logic        misaligned;
  logic        req_fire;

  // A misaligned PC never reaches the bus; it is reported as a fault instead
  assign misaligned = (pc_reg[1:0] != 2'b00);
  assign req_fire   = ifetch_req_valid && ifetch_req_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; redirect outranks every other transition
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          // An accepted request still owes us a response, so wait for it
          state_next = req_fire ? S_WAIT : S_REQ;
        end else if (misaligned) begin
          state_next = S_HOLD;
        end else if (ifetch_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ifetch_rsp_valid) begin
          state_next = (redirect_valid || kill_reg) ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) begin
          state_next = S_REQ;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // PC, held instruction, fault flag and kill marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      inst_reg     <= NOP_INST;
      inst_err_reg <= 1'b0;
      kill_reg     <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // Stale responses from before reset are simply not looked at here
          if (redirect_valid) pc_reg <= redirect_pc;
        end
        S_REQ: begin
          if (redirect_valid) begin
            pc_reg   <= redirect_pc;
            kill_reg <= req_fire;
          end else if (misaligned) begin
            inst_reg     <= NOP_INST;
            inst_err_reg <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc_reg   <= redirect_pc;
            // A response arriving this same cycle is the one being discarded
            kill_reg <= !ifetch_rsp_valid;
          end else if (ifetch_rsp_valid) begin
            if (kill_reg) begin
              kill_reg <= 1'b0;
            end else begin
              inst_reg     <= ifetch_rsp_data;
              inst_err_reg <= ifetch_rsp_err;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_reg       <= redirect_pc;
            inst_reg     <= NOP_INST;
            inst_err_reg <= 1'b0;
          end else if (inst_ready) begin
            pc_reg       <= pc_reg + 64'd4;
            inst_reg     <= NOP_INST;
            inst_err_reg <= 1'b0;
          end
        end
        default: begin
          kill_reg <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    ifetch_req_valid = (state_reg == S_REQ) && !misaligned;
    ifetch_addr      = pc_reg;
    inst_valid       = (state_reg == S_HOLD);
    inst             = inst_reg;
    pc               = pc_reg;
    inst_err         = inst_err_reg;
  end

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// Directed bench for the fetch unit: a per-cycle vector table of bus/decode
// inputs with hand-computed expected outputs, plus a mid-cycle reset check.
module tb_ysyx_22050133_ifu;

  localparam logic [63:0] R  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] N  = 32'h0000_0013;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifetch_req_valid;
  logic        ifetch_req_ready;
  logic [63:0] ifetch_addr;
  logic        ifetch_rsp_valid;
  logic [31:0] ifetch_rsp_data;
  logic        ifetch_rsp_err;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        inst_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22050133_ifu dut (
    .clk              (clk),
    .rst              (rst),
    .ifetch_req_valid (ifetch_req_valid),
    .ifetch_req_ready (ifetch_req_ready),
    .ifetch_addr      (ifetch_addr),
    .ifetch_rsp_valid (ifetch_rsp_valid),
    .ifetch_rsp_data  (ifetch_rsp_data),
    .ifetch_rsp_err   (ifetch_rsp_err),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst             (inst),
    .pc               (pc),
    .inst_err         (inst_err)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        rerr;
    logic        redir;
    logic [63:0] rpc;
    logic        iready;
    logic        e_req;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic rst_i, input logic rdy, input logic rv,
                   input logic [31:0] rdata, input logic rerr, input logic redir,
                   input logic [63:0] rpc, input logic iready,
                   input logic e_req, input logic e_iv, input logic [31:0] e_inst,
                   input logic [63:0] e_pc, input logic e_err);
    vec_t t;
    t.rst = rst_i; t.rdy = rdy; t.rv = rv; t.rdata = rdata; t.rerr = rerr;
    t.redir = redir; t.rpc = rpc; t.iready = iready;
    t.e_req = e_req; t.e_iv = e_iv; t.e_inst = e_inst; t.e_pc = e_pc; t.e_err = e_err;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic check_outputs(input int row, input logic e_req, input logic e_iv,
                               input logic [31:0] e_inst, input logic [63:0] e_pc,
                               input logic e_err);
    chk("ifetch_req_valid", row, {63'd0, ifetch_req_valid}, {63'd0, e_req});
    if (e_req) chk("ifetch_addr", row, ifetch_addr, e_pc);
    chk("inst_valid", row, {63'd0, inst_valid}, {63'd0, e_iv});
    chk("inst", row, {32'd0, inst}, {32'd0, e_inst});
    chk("pc", row, pc, e_pc);
    chk("inst_err", row, {63'd0, inst_err}, {63'd0, e_err});
  endtask

  initial begin
    rst = 1'b1;
    ifetch_req_ready = 1'b0; ifetch_rsp_valid = 1'b0; ifetch_rsp_data = 32'd0;
    ifetch_rsp_err = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0; inst_ready = 1'b0;

    //  rst rdy rv rdata           rerr rdr rpc                     irdy  req iv inst           pc                       err
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                0,    0, 0, N,             R,                       0); // 0 idle
    v(0, 1, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             R,                       0); // 1 req accepted
    v(0, 0, 1, 32'h0000_0093,   0, 0, 64'h0,                0,    0, 0, N,             R,                       0); // 2 zero-latency rsp
    for (int i = 0; i < 5; i++)
      v(0, 0, 0, 32'h0,         0, 0, 64'h0,                0,    0, 1, 32'h0000_0093, R,                       0); // 3-7 backpressure
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                1,    0, 1, 32'h0000_0093, R,                       0); // 8 consume
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             R + 64'd4,               0); // 9 unaccepted req
    v(0, 1, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             R + 64'd4,               0); // 10 accepted
    v(0, 0, 0, 32'h0,           0, 1, 64'h8000_1000,        0,    0, 0, N,             R + 64'd4,               0); // 11 redirect in wait
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                0,    0, 0, N,             64'h8000_1000,           0); // 12
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                0,    0, 0, N,             64'h8000_1000,           0); // 13
    v(0, 0, 1, 32'hDEAD_BEEF,   0, 0, 64'h0,                0,    0, 0, N,             64'h8000_1000,           0); // 14 killed rsp
    v(0, 1, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             64'h8000_1000,           0); // 15 refetch
    v(0, 0, 1, 32'h0000_0293,   0, 0, 64'h0,                0,    0, 0, N,             64'h8000_1000,           0); // 16
    v(0, 0, 0, 32'h0,           0, 1, 64'h8000_0102,        1,    0, 1, 32'h0000_0293, 64'h8000_1000,           0); // 17 redirect beats consume
    v(0, 1, 0, 32'h0,           0, 0, 64'h0,                0,    0, 0, N,             64'h8000_0102,           0); // 18 misaligned: no req
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                0,    0, 1, N,             64'h8000_0102,           1); // 19 fault held
    v(0, 0, 0, 32'h0,           0, 1, 64'h8000_0008,        0,    0, 1, N,             64'h8000_0102,           1); // 20 redirect from hold
    v(0, 1, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             64'h8000_0008,           0); // 21
    v(0, 0, 1, 32'h0000_0013,   1, 0, 64'h0,                0,    0, 0, N,             64'h8000_0008,           0); // 22 bus error
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                1,    0, 1, N,             64'h8000_0008,           1); // 23 consume fault
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             64'h8000_000C,           0); // 24
    v(0, 0, 0, 32'h0,           0, 1, 64'h8000_2000,        0,    1, 0, N,             64'h8000_000C,           0); // 25 redirect, not accepted
    v(0, 1, 0, 32'h0,           0, 1, 64'h8000_3000,        0,    1, 0, N,             64'h8000_2000,           0); // 26 redirect + accept
    v(0, 0, 1, 32'h1111_1111,   0, 0, 64'h0,                0,    0, 0, N,             64'h8000_3000,           0); // 27 killed rsp
    v(0, 1, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             64'h8000_3000,           0); // 28
    v(0, 0, 1, 32'h2222_2222,   0, 1, 64'h8000_4000,        0,    0, 0, N,             64'h8000_3000,           0); // 29 rsp + redirect
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             64'h8000_4000,           0); // 30
    v(0, 1, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             64'h8000_4000,           0); // 31 into wait
    v(1, 0, 0, 32'h0,           0, 0, 64'h0,                0,    0, 0, N,             R,                       0); // 32 async reset
    v(0, 0, 1, 32'hDEAD_BEEF,   0, 0, 64'h0,                0,    0, 0, N,             R,                       0); // 33 stale rsp in idle
    v(0, 1, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             R,                       0); // 34
    v(0, 0, 1, 32'h0000_0055,   0, 0, 64'h0,                0,    0, 0, N,             R,                       0); // 35
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                0,    0, 1, 32'h0000_0055, R,                       0); // 36
    v(0, 0, 0, 32'h0,           0, 1, TOP,                  1,    0, 1, 32'h0000_0055, R,                       0); // 37 redirect to top
    v(0, 1, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             TOP,                     0); // 38
    v(0, 0, 1, 32'h0000_0077,   0, 0, 64'h0,                0,    0, 0, N,             TOP,                     0); // 39
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                1,    0, 1, 32'h0000_0077, TOP,                     0); // 40 consume, pc wraps
    v(0, 0, 0, 32'h0,           0, 0, 64'h0,                0,    1, 0, N,             64'h0,                   0); // 41

    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst              = vecs[i].rst;
      ifetch_req_ready = vecs[i].rdy;
      ifetch_rsp_valid = vecs[i].rv;
      ifetch_rsp_data  = vecs[i].rdata;
      ifetch_rsp_err   = vecs[i].rerr;
      redirect_valid   = vecs[i].redir;
      redirect_pc      = vecs[i].rpc;
      inst_ready       = vecs[i].iready;
      #1;
      check_outputs(i, vecs[i].e_req, vecs[i].e_iv, vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_err);
      $display("row %0d: req=%b addr=%h iv=%b inst=%h pc=%h err=%b",
               i, ifetch_req_valid, ifetch_addr, inst_valid, inst, pc, inst_err);
    end

    // Reset asserted away from any clock edge while a fetch is outstanding
    @(negedge clk);
    ifetch_req_ready = 1'b1; ifetch_rsp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    #1;
    check_outputs(100, 1'b1, 1'b0, N, 64'h0, 1'b0);
    @(posedge clk);
    ifetch_req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_outputs(101, 1'b0, 1'b0, N, R, 1'b0);
    $display("row 101: mid-cycle reset req=%b iv=%b pc=%h", ifetch_req_valid, inst_valid, pc);
    @(negedge clk);
    rst = 1'b0; ifetch_rsp_valid = 1'b1; ifetch_rsp_data = 32'hDEAD_BEEF;
    #1;
    check_outputs(102, 1'b0, 1'b0, N, R, 1'b0);
    @(negedge clk);
    ifetch_rsp_valid = 1'b0;
    #1;
    check_outputs(103, 1'b1, 1'b0, N, R, 1'b0);
    $display("row 103: after reset req=%b addr=%h", ifetch_req_valid, ifetch_addr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
